// File: rtl/draw_pkg.sv
// Shared screen geometry, pixel bundle and arbiter state encoding
// for the pixel drawing path.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    GAP
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pixel_t;

endpackage

// File: rtl/pixel_out_reg.sv
// Registered pixel stage toward the VGA adapter; clips off-screen
// pixels and counts them in a saturating counter.
module pixel_out_reg
  import draw_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           accept,
  input  pixel_t         pix,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic [7:0]     drop_count
);

  logic on_screen;
  logic emit;
  logic drop;

  assign on_screen = (pix.x < X_W'(SCREEN_W))
                  && (pix.y < Y_W'(SCREEN_H));
  assign emit = accept && on_screen;
  assign drop = accept && !on_screen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      drop_count <= '0;
    end else begin
      plot <= emit;
      if (emit) begin
        x      <= pix.x;
        y      <= pix.y;
        colour <= pix.c;
      end
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: rtl/pixel_arbiter.sv
// Two-client burst arbiter for the VGA pixel port with
// alternating priority on simultaneous requests.
module pixel_arbiter
  import draw_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req0,
  input  logic           req1,
  input  logic           pix_valid0,
  input  logic           pix_valid1,
  input  logic           done0,
  input  logic           done1,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] c0,
  input  logic [C_W-1:0] c1,
  output logic           grant0,
  output logic           grant1,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic [7:0]     drop_count
);

  state_t state;
  state_t next;
  logic   last;
  logic   accept;
  pixel_t pix;

  // last=1 means client1 was served most recently
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next;
      if (state == OWN0 && next == GAP)
        last <= 1'b0;
      if (state == OWN1 && next == GAP)
        last <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          next = last ? OWN0 : OWN1;
        else if (req0)
          next = OWN0;
        else if (req1)
          next = OWN1;
      end
      OWN0: begin
        if (!req0 || (pix_valid0 && done0))
          next = GAP;
      end
      OWN1: begin
        if (!req1 || (pix_valid1 && done1))
          next = GAP;
      end
      GAP:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    accept = 1'b0;
    pix    = '0;
    busy   = (state != IDLE);
    unique case (1'b1)
      (state == OWN0): begin
        grant0 = 1'b1;
        accept = req0 && pix_valid0;
        pix    = '{x: x0, y: y0, c: c0};
      end
      (state == OWN1): begin
        grant1 = 1'b1;
        accept = req1 && pix_valid1;
        pix    = '{x: x1, y: y1, c: c1};
      end
      default: ;
    endcase
  end

  pixel_out_reg u_out (
    .clock      (clock),
    .reset_n    (reset_n),
    .accept     (accept),
    .pix        (pix),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .drop_count (drop_count)
  );

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning), with clock and reset first:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  client k requests ownership of the pixel port for one burst (one stair rectangle).
- pix_valid0, pix_valid1  in  1  client k presents a pixel this cycle.
- done0, done1  in  1  client k marks the presented pixel as the last of its burst; qualified by pix_valid_k.
- x0, x1  in  8  client pixel x coordinate.
- y0, y1  in  7  client pixel y coordinate.
- c0, c1  in  3  client pixel colour.
- grant0, grant1  out  1  client k currently owns the port.
- x  out  8  pixel x to the VGA adapter.
- y  out  7  pixel y to the VGA adapter.
- colour  out  3  pixel colour to the VGA adapter.
- plot  out  1  write strobe to the VGA adapter.
- busy  out  1  the arbiter is not in IDLE.
- drop_count  out  8  count of suppressed off-screen pixels.

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, OWN0, OWN1 and GAP, held in a state register.
REQ-003 IDLE transitions: req0 and req1 both high -> the client that is not last-served; one request only -> that client's OWN state; no request -> remain in IDLE.
REQ-004 OWNk transitions: pix_valid_k and done_k both high -> GAP, with that final pixel still forwarded; req_k low -> GAP (abort), with no pixel forwarded that cycle; otherwise remain in OWNk.
REQ-005 GAP SHALL return to IDLE after exactly one cycle, and the last-served pointer SHALL be set to the client that just owned the port.
REQ-006 grant_k SHALL be a decode of the registered state (high only in OWNk), and grant0 and grant1 SHALL never be high together.
REQ-007 Pixel forwarding: in OWNk, a cycle with pix_valid_k high SHALL accept the pixel; inputs of the non-owning client SHALL be ignored.
REQ-008 Outputs x, y, colour and plot SHALL be registered, so a pixel accepted in cycle n appears with plot=1 in cycle n+1; plot SHALL be 0 in every other cycle.
REQ-009 Latency: req_k rising in IDLE at cycle n SHALL give grant_k=1 at cycle n+1, and the first pixel offered at n+1 SHALL plot at n+2.
REQ-010 Clipping: an accepted pixel with x>159 or y>119 SHALL NOT plot; x, y and colour SHALL hold their previous values, and drop_count SHALL increment, saturating at 255.
REQ-011 An off-screen pixel carrying done_k SHALL still end the burst, as in REQ-004.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 Simultaneous done_k and req_k low in OWNk SHALL be treated as an abort: the pixel is not forwarded and the FSM goes to GAP.

Reset
REQ-014 Asserting reset_n low SHALL immediately force: state IDLE, grant0/1=0, plot=0, x=0, y=0, colour=0, busy=0, drop_count=0, last-served pointer=client1 (so client0 wins the first tie).
REQ-015 Reset asserted mid-burst SHALL discard the burst with no pixel emitted; after release, arbitration SHALL restart from IDLE.

Structure
REQ-016 A shared package draw_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, the X/Y/colour widths (8/7/3) and the state enumeration.
REQ-017 The registered output stage, including the clip test and drop_count, SHALL be a sub-module named pixel_out_reg; the FSM and pointer stay in pixel_arbiter.

Verification
REQ-018 Reset release, then req0=1 alone with 3 pixels (20,40,c=4),(21,40),(22,40,done) -> grant0 at cycle 1, plot high cycles 2-4 with matching x/y, busy low at cycle 5.
REQ-019 req0 and req1 raised in the same cycle from reset -> client0 granted first; after its done, GAP for 1 cycle, then grant1, with no overlap of grants.
REQ-020 Repeated simultaneous requests over 4 bursts -> grants alternate 0,1,0,1.
REQ-021 Client0 offers x=170, y=10 and then x=159, y=119 -> the first pixel is not plotted and drop_count=1; the second plots at (159,119).
REQ-022 req0 dropped mid-burst after 2 pixels -> 2 plots only, then GAP, IDLE; reset_n pulsed low mid-burst -> all outputs 0 asynchronously and no further plot.
